// File: rtl/snitch_icache_pkg.sv
// Shared types and helpers for the icache tag store.
//   tag_fsm_e      : tag array sweep/idle state
//   tag_entry_pack : builds a {valid, err, tag} entry for a given tag width
package snitch_icache_pkg;

  typedef enum logic [1:0] {
    TagInit,
    TagIdle,
    TagFlush
  } tag_fsm_e;

  localparam int unsigned TagWidthMax   = 32;
  localparam int unsigned EntryWidthMax = TagWidthMax + 2;
  localparam int unsigned EntryIdxWidth = $clog2(EntryWidthMax);

  // Packs an entry LSB-aligned; callers truncate to TagWidth+2 bits.
  function automatic logic [EntryWidthMax-1:0] tag_entry_pack(
    input logic                   valid,
    input logic                   err,
    input logic [TagWidthMax-1:0] tag,
    input int unsigned            tag_width
  );
    logic [EntryWidthMax-1:0] entry;
    entry = EntryWidthMax'(tag);
    entry[EntryIdxWidth'(tag_width)]     = err;
    entry[EntryIdxWidth'(tag_width + 1)] = valid;
    return entry;
  endfunction

endpackage

// File: rtl/snitch_icache_tag_bank.sv
// One set of the tag store: single-port memory, 1-cycle read latency.
//   clk_i   : clock
//   en_i    : access enable
//   we_i    : write enable (read when low)
//   addr_i  : line index
//   wdata_i : entry to write
//   rdata_o : entry read on the previous enabled read cycle
module snitch_icache_tag_bank
  import snitch_icache_pkg::*;
#(
  parameter int unsigned LineCount = 128,
  parameter int unsigned DataWidth = 22,
  parameter int unsigned AddrWidth = $clog2(LineCount)
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem [LineCount];

  // Behavioural 1RW array standing in for the SRAM macro; contents are
  // defined only after the top-level init sweep.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/snitch_icache_tag_array.sv
// Multi-set icache tag store with tag compare, hardware init and flush.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   flush_i/flush_busy_o  : invalidate request / sweep in progress
//   lookup_*              : lookup request (valid/ready, line index, tag)
//   rsp_*                 : lookup result one cycle after acceptance
//   write_*               : refill request (valid/ready, line, one-hot set, tag, err)
module snitch_icache_tag_array
  import snitch_icache_pkg::*;
#(
  parameter int unsigned SetCount  = 4,
  parameter int unsigned LineCount = 128,
  parameter int unsigned TagWidth  = 20,
  parameter int unsigned AddrWidth = $clog2(LineCount)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  output logic                 flush_busy_o,
  input  logic                 lookup_valid_i,
  output logic                 lookup_ready_o,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  input  logic [TagWidth-1:0]  lookup_tag_i,
  output logic                 rsp_valid_o,
  output logic [SetCount-1:0]  rsp_hit_o,
  output logic                 rsp_err_o,
  output logic                 rsp_multi_hit_o,
  input  logic                 write_valid_i,
  output logic                 write_ready_o,
  input  logic [AddrWidth-1:0] write_addr_i,
  input  logic [SetCount-1:0]  write_set_i,
  input  logic [TagWidth-1:0]  write_tag_i,
  input  logic                 write_err_i
);

  localparam int unsigned EntryWidth = TagWidth + 2;

  tag_fsm_e             state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic                 sweep, idle, sweep_en, idle_en;
  logic                 write_acc, lookup_acc;
  logic                 rsp_valid_q;
  logic [TagWidth-1:0]  tag_q;
  logic [EntryWidth-1:0] write_entry;
  logic [SetCount-1:0]  bank_en, bank_we;
  logic [AddrWidth-1:0] bank_addr;
  logic [EntryWidth-1:0] bank_wdata;
  logic [EntryWidth-1:0] bank_rdata [SetCount];
  logic [SetCount-1:0]  hit;
  logic                 err_any;

  // State, sweep counter and lookup response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= TagInit;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= lookup_acc;
      if (lookup_acc) begin
        tag_q <= lookup_tag_i;
      end
    end
  end

  // Next state: sweep one line per cycle, flush only from idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sweep   = 1'b0;
    idle    = 1'b0;
    case (state_q)
      TagInit, TagFlush: begin
        sweep = 1'b1;
        cnt_d = cnt_q + AddrWidth'(1);
        if (cnt_q == AddrWidth'(LineCount - 1)) begin
          state_d = TagIdle;
          cnt_d   = '0;
        end
      end
      TagIdle: begin
        idle = 1'b1;
        if (flush_i) begin
          state_d = TagFlush;
          cnt_d   = '0;
        end
      end
      default: state_d = TagInit;
    endcase
  end

  // Reset masks every handshake and the sweep itself, so outputs read 0.
  assign sweep_en       = sweep & ~rst_i;
  assign idle_en        = idle & ~rst_i;
  assign flush_busy_o   = sweep_en;
  assign write_ready_o  = idle_en;
  assign lookup_ready_o = idle_en & ~write_valid_i;
  assign write_acc      = write_valid_i & write_ready_o;
  assign lookup_acc     = lookup_valid_i & lookup_ready_o;

  assign write_entry = EntryWidth'(tag_entry_pack(1'b1, write_err_i,
                                                  TagWidthMax'(write_tag_i), TagWidth));

  // Bank arbitration: sweep > write > lookup, per-set write enables.
  always_comb begin
    bank_addr  = lookup_addr_i;
    bank_wdata = write_entry;
    bank_en    = '0;
    bank_we    = '0;
    if (sweep_en) begin
      bank_addr  = cnt_q;
      bank_wdata = '0;
      bank_en    = '1;
      bank_we    = '1;
    end else if (write_acc) begin
      bank_addr = write_addr_i;
      bank_en   = write_set_i;
      bank_we   = write_set_i;
    end else if (lookup_acc) begin
      bank_en = '1;
    end
  end

  for (genvar g = 0; g < SetCount; g++) begin : gen_bank
    snitch_icache_tag_bank #(
      .LineCount(LineCount),
      .DataWidth(EntryWidth),
      .AddrWidth(AddrWidth)
    ) i_bank (
      .clk_i  (clk_i),
      .en_i   (bank_en[g]),
      .we_i   (bank_we[g]),
      .addr_i (bank_addr),
      .wdata_i(bank_wdata),
      .rdata_o(bank_rdata[g])
    );
  end

  // Compare and reduce; everything is forced to 0 without a valid response.
  always_comb begin
    hit     = '0;
    err_any = 1'b0;
    for (int i = 0; i < SetCount; i++) begin
      hit[i]  = rsp_valid_q & bank_rdata[i][TagWidth+1]
              & (bank_rdata[i][TagWidth-1:0] == tag_q);
      err_any = err_any | (hit[i] & bank_rdata[i][TagWidth]);
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_hit_o       = hit;
  assign rsp_err_o       = err_any;
  assign rsp_multi_hit_o = (hit & (hit - SetCount'(1))) != '0;

endmodule

// File: tb/tb_snitch_icache_tag_array.sv
// Self-checking bench for snitch_icache_tag_array (4 sets, 64 lines, 20-bit tags).
module tb_snitch_icache_tag_array;

  localparam int SC = 4;
  localparam int LC = 64;
  localparam int TW = 20;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          flush_busy;
  logic          lookup_valid;
  logic          lookup_ready;
  logic [AW-1:0] lookup_addr;
  logic [TW-1:0] lookup_tag;
  logic          rsp_valid;
  logic [SC-1:0] rsp_hit;
  logic          rsp_err;
  logic          rsp_multi_hit;
  logic          write_valid;
  logic          write_ready;
  logic [AW-1:0] write_addr;
  logic [SC-1:0] write_set;
  logic [TW-1:0] write_tag;
  logic          write_err;

  always #5 clk = ~clk;

  snitch_icache_tag_array #(
    .SetCount (SC),
    .LineCount(LC),
    .TagWidth (TW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .flush_busy_o   (flush_busy),
    .lookup_valid_i (lookup_valid),
    .lookup_ready_o (lookup_ready),
    .lookup_addr_i  (lookup_addr),
    .lookup_tag_i   (lookup_tag),
    .rsp_valid_o    (rsp_valid),
    .rsp_hit_o      (rsp_hit),
    .rsp_err_o      (rsp_err),
    .rsp_multi_hit_o(rsp_multi_hit),
    .write_valid_i  (write_valid),
    .write_ready_o  (write_ready),
    .write_addr_i   (write_addr),
    .write_set_i    (write_set),
    .write_tag_i    (write_tag),
    .write_err_i    (write_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: line contents per set, remaining sweep cycles, pending response.
  logic          mv [SC][LC];
  logic          me [SC][LC];
  logic [TW-1:0] mt [SC][LC];
  int            busy_left = LC;
  logic          model_started = 1'b0;
  logic          e_valid = 1'b0;
  logic [SC-1:0] e_hit = '0;
  logic          e_err = 1'b0;
  logic          e_multi = 1'b0;

  task automatic model_clear();
    for (int s = 0; s < SC; s++)
      for (int l = 0; l < LC; l++) begin
        mv[s][l] = 1'b0; me[s][l] = 1'b0; mt[s][l] = '0;
      end
  endtask

  // Applies one clock edge to the model using the inputs held before it.
  task automatic model_step();
    e_valid = 1'b0; e_hit = '0; e_err = 1'b0; e_multi = 1'b0;
    if (rst) begin
      busy_left = LC;
      model_clear();
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (write_valid) begin
        for (int s = 0; s < SC; s++)
          if (write_set[s]) begin
            mv[s][write_addr] = 1'b1;
            me[s][write_addr] = write_err;
            mt[s][write_addr] = write_tag;
          end
      end else if (lookup_valid) begin
        e_valid = 1'b1;
        for (int s = 0; s < SC; s++)
          e_hit[s] = mv[s][lookup_addr] && (mt[s][lookup_addr] == lookup_tag);
        for (int s = 0; s < SC; s++)
          if (e_hit[s] && me[s][lookup_addr]) e_err = 1'b1;
        e_multi = ($countones(e_hit) > 1);
      end
      if (flush) begin
        busy_left = LC;
        model_clear();
      end
    end
    model_started = 1'b1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_started) begin
      chk("busy",        32'(flush_busy),   32'(!rst && busy_left > 0));
      chk("write_ready", 32'(write_ready),  32'(!rst && busy_left == 0));
      chk("lookup_ready",32'(lookup_ready), 32'(!rst && busy_left == 0 && !write_valid));
      chk("rsp_valid",   32'(rsp_valid),    32'(e_valid));
      chk("rsp_hit",     32'(rsp_hit),      32'(e_hit));
      chk("rsp_err",     32'(rsp_err),      32'(e_err));
      chk("rsp_multi",   32'(rsp_multi_hit),32'(e_multi));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    flush = 1'b0; lookup_valid = 1'b0; lookup_addr = '0; lookup_tag = '0;
    write_valid = 1'b0; write_addr = '0; write_set = '0; write_tag = '0; write_err = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic [SC-1:0] set, input logic [TW-1:0] tag,
                          input logic err);
    write_valid = 1'b1; write_addr = AW'(addr); write_set = set; write_tag = tag; write_err = err;
    cyc();
    write_valid = 1'b0; write_set = '0;
  endtask

  task automatic do_lookup(input int addr, input logic [TW-1:0] tag);
    lookup_valid = 1'b1; lookup_addr = AW'(addr); lookup_tag = tag;
    cyc();
    lookup_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (flush_busy && n < 200) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    idle_in();
    cyc(); cyc(); cyc();
    chk("reset_busy",   32'(flush_busy),   32'h0);
    chk("reset_rvalid", 32'(rsp_valid),    32'h0);
    chk("reset_lready", 32'(lookup_ready), 32'h0);
    chk("reset_wready", 32'(write_ready),  32'h0);
    rst = 1'b0;
    #1;
    chk("init_busy_rise", 32'(flush_busy), 32'h1);
    count_busy(n);
    chk("init_len", 32'(n), 32'd64);

    // All lines miss after init.
    for (int l = 0; l < LC; l++) begin
      do_lookup(l, TW'($urandom));
      chk("init_miss", 32'(rsp_hit), 32'h0);
    end

    // Single-set refill then lookup.
    do_write(5, 4'b0100, 20'hABCDE, 1'b0);
    do_lookup(5, 20'hABCDE);
    chk("hit5_valid", 32'(rsp_valid), 32'h1);
    chk("hit5_hit",   32'(rsp_hit),   32'h4);
    chk("hit5_err",   32'(rsp_err),   32'h0);
    chk("hit5_multi", 32'(rsp_multi_hit), 32'h0);

    // Zero set mask is a no-op.
    do_write(5, 4'b0000, 20'hFFFFF, 1'b1);
    do_lookup(5, 20'hABCDE);
    chk("noop_hit", 32'(rsp_hit), 32'h4);

    // Multi-hit with error on one set.
    do_write(9, 4'b0001, 20'h00011, 1'b0);
    do_write(9, 4'b0100, 20'h00011, 1'b1);
    do_lookup(9, 20'h00011);
    chk("multi_hit",  32'(rsp_hit),       32'h5);
    chk("multi_err",  32'(rsp_err),       32'h1);
    chk("multi_flag", 32'(rsp_multi_hit), 32'h1);

    // Write beats a concurrent lookup; retried lookup sees it.
    write_valid = 1'b1; write_addr = 6'd12; write_set = 4'b1000; write_tag = 20'h12345;
    lookup_valid = 1'b1; lookup_addr = 6'd12; lookup_tag = 20'h12345;
    #1;
    chk("conflict_lready", 32'(lookup_ready), 32'h0);
    chk("conflict_wready", 32'(write_ready),  32'h1);
    cyc();
    write_valid = 1'b0; write_set = '0;
    cyc();
    lookup_valid = 1'b0;
    chk("retry_hit", 32'(rsp_hit), 32'h8);

    // Fill 10 lines, then flush with a lookup in the same cycle.
    for (int l = 20; l < 30; l++) do_write(l, 4'b0010, TW'(32'h100 + l), 1'b0);
    lookup_valid = 1'b1; lookup_addr = 6'd20; lookup_tag = 20'h114;
    flush = 1'b1;
    cyc();
    lookup_valid = 1'b0; flush = 1'b0;
    chk("preflush_hit", 32'(rsp_hit), 32'h2);
    n = 0;
    while (flush_busy && n < 200) begin
      flush = (n == 10);
      cyc();
      n++;
    end
    flush = 1'b0;
    chk("flush_len", 32'(n), 32'd64);
    for (int l = 20; l < 30; l++) begin
      do_lookup(l, TW'(32'h100 + l));
      chk("postflush_miss", 32'(rsp_hit), 32'h0);
    end

    // Reset in the middle of a sweep restarts it.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int k = 0; k < 30; k++) cyc();
    rst = 1'b1;
    lookup_valid = 1'b1; lookup_addr = 6'd5; lookup_tag = 20'hABCDE;
    cyc(); cyc();
    chk("midrst_busy", 32'(flush_busy), 32'h0);
    rst = 1'b0;
    #1;
    count_busy(n);
    lookup_valid = 1'b0;
    chk("rst_sweep_len", 32'(n), 32'd64);
    do_lookup(5, 20'hABCDE);
    chk("rst_miss", 32'(rsp_hit), 32'h0);

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
